// File: rtl/l2_arb_pkg.sv
// Shared types for the L1-to-L2 arbiter.
// FSM states and requester identifiers.
package l2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

endpackage

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing the L2 between the L1 I-cache and D-cache.
// One whole-line transaction in flight; grant held until mem_resp.
module l2_arbiter
  import l2_arb_pkg::*;
#(
  parameter int s_offset = 5,
  parameter int s_mask   = 2**s_offset,
  parameter int s_line   = 8*s_mask
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       i_address,
  input  logic              i_read,
  output logic [s_line-1:0] i_rdata,
  output logic              i_resp,
  input  logic [31:0]       d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [s_line-1:0] d_wdata,
  input  logic [s_mask-1:0] d_byte_enable256,
  output logic [s_line-1:0] d_rdata,
  output logic              d_resp,
  output logic [31:0]       mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [s_line-1:0] mem_wdata,
  output logic [s_mask-1:0] mem_byte_enable256,
  input  logic [s_line-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t r_state;
  req_id_t    r_last;

  logic [31:0]       r_addr;
  logic              r_read;
  logic              r_write;
  logic [s_line-1:0] r_wdata;
  logic [s_mask-1:0] r_be;

  logic w_i_pend;
  logic w_d_pend;
  logic w_take_i;
  logic w_take_d;
  logic w_busy;

  // Conflicts go to whichever side was not served last.
  always_comb begin
    w_i_pend = i_read;
    w_d_pend = d_read | d_write;
    w_take_i = 1'b0;
    w_take_d = 1'b0;
    if (r_state == IDLE) begin
      if (w_i_pend && w_d_pend) begin
        w_take_d = (r_last == REQ_I);
        w_take_i = (r_last == REQ_D);
      end else begin
        w_take_i = w_i_pend;
        w_take_d = w_d_pend;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= REQ_I;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_take_d)
            r_state <= SERVE_D;
          else if (w_take_i)
            r_state <= SERVE_I;
        end
        SERVE_I: begin
          if (mem_resp) begin
            r_state <= IDLE;
            r_last  <= REQ_I;
          end
        end
        SERVE_D: begin
          if (mem_resp) begin
            r_state <= IDLE;
            r_last  <= REQ_D;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Write beats read when the D-cache raises both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_take_d) begin
      r_addr  <= d_address;
      r_read  <= d_read & ~d_write;
      r_write <= d_write;
      r_wdata <= d_wdata;
      r_be    <= d_byte_enable256;
    end else if (w_take_i) begin
      r_addr  <= i_address;
      r_read  <= 1'b1;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_be    <= '0;
    end
  end

  assign w_busy = (r_state != IDLE);

  assign mem_address        = r_addr;
  assign mem_read           = w_busy & r_read;
  assign mem_write          = w_busy & r_write;
  assign mem_wdata          = r_wdata;
  assign mem_byte_enable256 = r_be;

  assign i_resp  = (r_state == SERVE_I) & mem_resp;
  assign d_resp  = (r_state == SERVE_D) & mem_resp;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: per-cycle vector table plus
// hand sequences for conflict alternation and async reset.
module tb_l2_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_address;
  logic         i_read;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic [31:0]  d_address;
  logic         d_read;
  logic         d_write;
  logic [255:0] d_wdata;
  logic [31:0]  d_byte_enable256;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [255:0] mem_wdata;
  logic [31:0]  mem_byte_enable256;
  logic [255:0] mem_rdata;
  logic         mem_resp;

  int n_chk  = 0;
  int n_fail = 0;

  l2_arbiter dut (
    .clk                (clk),
    .rst                (rst),
    .i_address          (i_address),
    .i_read             (i_read),
    .i_rdata            (i_rdata),
    .i_resp             (i_resp),
    .d_address          (d_address),
    .d_read             (d_read),
    .d_write            (d_write),
    .d_wdata            (d_wdata),
    .d_byte_enable256   (d_byte_enable256),
    .d_rdata            (d_rdata),
    .d_resp             (d_resp),
    .mem_address        (mem_address),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .mem_wdata          (mem_wdata),
    .mem_byte_enable256 (mem_byte_enable256),
    .mem_rdata          (mem_rdata),
    .mem_resp           (mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        ir;
    logic        dr;
    logic        dw;
    logic [31:0] ia;
    logic [31:0] da;
    logic        mr;
    logic        e_mrd;
    logic        e_mwr;
    logic        e_ir;
    logic        e_dr;
    logic [31:0] e_ma;
  } vec_t;

  vec_t tbl[$];

  localparam logic [255:0] RD  = {32{8'hA5}};
  localparam logic [255:0] WD1 = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] WD2 = {8{32'h1234_5678}};
  localparam logic [31:0]  BE  = 32'h0000_00FF;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic setin(input logic ir, input logic dr, input logic dw,
                       input logic [31:0] ia, input logic [31:0] da,
                       input logic mr);
    i_read    = ir;
    d_read    = dr;
    d_write   = dw;
    i_address = ia;
    d_address = da;
    mem_resp  = mr;
  endtask

  function automatic vec_t mk(
    input string nm, input logic ir, input logic dr, input logic dw,
    input logic [31:0] ia, input logic [31:0] da, input logic mr,
    input logic emrd, input logic emwr, input logic eir,
    input logic edr, input logic [31:0] ema);
    vec_t v;
    v.nm = nm; v.ir = ir; v.dr = dr; v.dw = dw;
    v.ia = ia; v.da = da; v.mr = mr;
    v.e_mrd = emrd; v.e_mwr = emwr; v.e_ir = eir;
    v.e_dr = edr; v.e_ma = ema;
    return v;
  endfunction

  task automatic outs(input string nm, input logic emrd, input logic emwr,
                      input logic eir, input logic edr,
                      input logic [31:0] ema);
    chk({nm, ".mem_read"},  256'(mem_read),    256'(emrd));
    chk({nm, ".mem_write"}, 256'(mem_write),   256'(emwr));
    chk({nm, ".i_resp"},    256'(i_resp),      256'(eir));
    chk({nm, ".d_resp"},    256'(d_resp),      256'(edr));
    chk({nm, ".mem_addr"},  256'(mem_address), 256'(ema));
  endtask

  localparam logic [31:0] A1 = 32'h0000_1000;
  localparam logic [31:0] AD = 32'h8000_0040;
  localparam logic [31:0] A2 = 32'h0000_2000;
  localparam logic [31:0] A3 = 32'h0000_3000;

  initial begin
    tbl.push_back(mk("i_idle",   1,0,0, A1,0, 0, 0,0,0,0, 0));
    tbl.push_back(mk("i_gnt",    1,0,0, A1,0, 0, 1,0,0,0, A1));
    tbl.push_back(mk("i_wait1",  1,0,0, A1,0, 0, 1,0,0,0, A1));
    tbl.push_back(mk("i_wait2",  1,0,0, A1,0, 0, 1,0,0,0, A1));
    tbl.push_back(mk("i_wait3",  1,0,0, A1,0, 0, 1,0,0,0, A1));
    tbl.push_back(mk("i_resp",   1,0,0, A1,0, 1, 1,0,1,0, A1));
    tbl.push_back(mk("i_gap",    0,0,0, 0,0,  0, 0,0,0,0, A1));
    tbl.push_back(mk("d_idle",   0,0,1, 0,AD, 0, 0,0,0,0, A1));
    tbl.push_back(mk("d_gnt",    0,0,1, 0,AD, 0, 0,1,0,0, AD));
    tbl.push_back(mk("d_resp",   0,0,1, 0,AD, 1, 0,1,0,1, AD));
    tbl.push_back(mk("d_gap",    0,0,0, 0,0,  0, 0,0,0,0, AD));
    tbl.push_back(mk("spur",     0,0,0, 0,0,  1, 0,0,0,0, AD));
    tbl.push_back(mk("dr_idle",  1,0,0, A2,0, 0, 0,0,0,0, AD));
    tbl.push_back(mk("dr_gnt",   1,0,0, A2,0, 0, 1,0,0,0, A2));
    tbl.push_back(mk("dr_low",   0,0,0, 0,0,  0, 1,0,0,0, A2));
    tbl.push_back(mk("dr_hold",  0,0,0, 0,0,  0, 1,0,0,0, A2));
    tbl.push_back(mk("dr_resp",  0,0,0, 0,0,  1, 1,0,1,0, A2));
    tbl.push_back(mk("rw_idle",  0,1,1, 0,A3, 0, 0,0,0,0, A2));
    tbl.push_back(mk("rw_gnt",   0,1,1, 0,A3, 0, 0,1,0,0, A3));
    tbl.push_back(mk("rw_resp",  0,0,0, 0,0,  1, 0,1,0,1, A3));
    tbl.push_back(mk("rw_gap",   0,0,0, 0,0,  0, 0,0,0,0, A3));

    rst = 1'b1;
    setin(0, 0, 0, 0, 0, 0);
    d_wdata          = WD1;
    d_byte_enable256 = BE;
    mem_rdata        = RD;
    #2;
    outs("rst", 0, 0, 0, 0, 0);
    chk("rst.mem_wdata", mem_wdata, '0);
    chk("rst.mem_be", 256'(mem_byte_enable256), '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[k]) begin
      @(negedge clk);
      setin(tbl[k].ir, tbl[k].dr, tbl[k].dw,
            tbl[k].ia, tbl[k].da, tbl[k].mr);
      #1;
      outs(tbl[k].nm, tbl[k].e_mrd, tbl[k].e_mwr,
           tbl[k].e_ir, tbl[k].e_dr, tbl[k].e_ma);
      if (tbl[k].e_mwr) begin
        chk({tbl[k].nm, ".wdata"}, mem_wdata, WD1);
        chk({tbl[k].nm, ".be"}, 256'(mem_byte_enable256), 256'(BE));
      end else if (tbl[k].e_mrd) begin
        chk({tbl[k].nm, ".wdata0"}, mem_wdata, '0);
        chk({tbl[k].nm, ".be0"}, 256'(mem_byte_enable256), '0);
      end
      if (tbl[k].e_ir)
        chk({tbl[k].nm, ".i_rdata"}, i_rdata, RD);
      if (tbl[k].e_dr)
        chk({tbl[k].nm, ".d_rdata"}, d_rdata, RD);
    end

    // Conflict alternation from reset: D, gap, I, gap, D.
    @(negedge clk);
    setin(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    setin(1, 1, 0, 32'h4000, 32'h5000, 0);
    #1 outs("cf_idle", 0, 0, 0, 0, 0);
    @(negedge clk);
    #1 outs("cf_d_gnt", 1, 0, 0, 0, 32'h5000);
    mem_resp = 1'b1;
    #1 outs("cf_d_resp", 1, 0, 0, 1, 32'h5000);
    @(negedge clk);
    mem_resp = 1'b0;
    #1 outs("cf_gap1", 0, 0, 0, 0, 32'h5000);
    @(negedge clk);
    #1 outs("cf_i_gnt", 1, 0, 0, 0, 32'h4000);
    mem_resp = 1'b1;
    #1 outs("cf_i_resp", 1, 0, 1, 0, 32'h4000);
    @(negedge clk);
    mem_resp = 1'b0;
    #1 outs("cf_gap2", 0, 0, 0, 0, 32'h4000);
    @(negedge clk);
    #1 outs("cf_d_again", 1, 0, 0, 0, 32'h5000);
    mem_resp = 1'b1;
    #1 outs("cf_d_resp2", 1, 0, 0, 1, 32'h5000);
    @(negedge clk);
    setin(0, 0, 0, 0, 0, 0);

    // Async reset while serving D, then re-grant from a fresh latch.
    @(negedge clk);
    setin(0, 0, 1, 0, 32'h6000, 0);
    d_wdata = WD1;
    #1 outs("ar_idle", 0, 0, 0, 0, 32'h5000);
    @(negedge clk);
    #1 outs("ar_gnt", 0, 1, 0, 0, 32'h6000);
    chk("ar_gnt.wdata", mem_wdata, WD1);
    d_address = 32'h7000;
    d_wdata   = WD2;
    #1 outs("ar_latched", 0, 1, 0, 0, 32'h6000);
    chk("ar_latched.wdata", mem_wdata, WD1);
    #1 rst = 1'b1;
    #1 outs("ar_async", 0, 0, 0, 0, 0);
    chk("ar_async.wdata", mem_wdata, '0);
    chk("ar_async.be", 256'(mem_byte_enable256), '0);
    @(negedge clk);
    rst = 1'b0;
    #1 outs("ar_release", 0, 0, 0, 0, 0);
    @(negedge clk);
    #1 outs("ar_regnt", 0, 1, 0, 0, 32'h7000);
    chk("ar_regnt.wdata", mem_wdata, WD2);
    chk("ar_regnt.be", 256'(mem_byte_enable256), 256'(BE));
    mem_resp = 1'b1;
    #1 outs("ar_resp", 0, 1, 0, 1, 32'h7000);
    @(negedge clk);
    setin(0, 0, 0, 0, 0, 0);
    #1 outs("ar_done", 0, 0, 0, 0, 32'h7000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
